negacyclic_poly_mult: RTL and testbench
=======================================

// Module: negacyclic_poly_mult
// PURPOSE
//  Self-sequencing polynomial multiplier: c = a*b mod (x^N +/- 1) mod Modulus_Q. Twist, pointwise multiply, N_INV scale
//  and untwist are done in hardware. Wraps one ntt_block_radix2_pipelined instance (NTT fwd/inv, mode-tagged).
//  Generalises the software-driven flow with a per-job cyclic/negacyclic mode select and output backpressure.
// PARAMETERS
//  W          100         lane width; operands and results < Modulus_Q
//  N          8           polynomial degree (power of 2); lanes
//  Modulus_Q  2147483777  prime modulus, 2N | Q-1
//  OMEGA      1061363846  primitive N-th root of unity mod Q
//  OMEGA_INV  1237364089  OMEGA^-1 mod Q
//  PSI        1323801281  primitive 2N-th root, PSI^2 = OMEGA
//  PSI_INV    2145878094  PSI^-1 mod Q
//  N_INV      1879048305  N^-1 mod Q
// PORTS
//  clk        in   1        clock
//  reset      in   1        synchronous, active-high
//  in_valid   in   1        job offered
//  in_ready   out  1        job accepted when in_valid & in_ready
//  neg_mode   in   1        1: negacyclic (x^N+1); 0: cyclic (x^N-1); sampled on accept
//  poly_a     in   W x N    coefficients a[0..N-1], unpacked [0:N-1]
//  poly_b     in   W x N    coefficients b[0..N-1]
//  out_valid  out  1        poly_c valid; held until out_ready
//  out_ready  in   1        consumer accepts result
//  poly_c     out  W x N    result c[0..N-1], each < Modulus_Q
//  busy       out  1        high in any state but IDLE
// BEHAVIOUR
//  Reset: state=IDLE, in_ready=1, out_valid=0, busy=0, poly_c=0, all buffers 0; NTT core gets the same reset.
//  Reset mid-job: the job is dropped with no output. in_ready=1 in the cycle after reset deasserts.
//  FSM: IDLE -> TWIST -> SEND_A -> SEND_B -> WAIT_NTT -> PMUL -> SEND_C -> WAIT_INTT -> SCALE -> DONE -> IDLE.
//   IDLE: in_ready=1. On accept, register a, b and neg_mode.
//   TWIST: a_t[i]=a[i]*TW[i], b_t[i]=b[i]*TW[i] mod Q. TW[i]=PSI^i if neg_mode, else 1.
//   SEND_A/SEND_B: back-to-back single-cycle data_valid_in pulses, iNTT_mode=0.
//   WAIT_NTT: 1st fwd output (valid & !mode_out) -> A_hat; 2nd -> B_hat; after the 2nd, go to PMUL.
//   PMUL: C_hat[i]=A_hat[i]*B_hat[i] mod Q (1 cycle). SEND_C: one pulse, iNTT_mode=1.
//   WAIT_INTT: wait for valid & mode_out=1, then capture c_raw.
//   SCALE: poly_c[i]=c_raw[i]*UT[i] mod Q. UT[i]=N_INV*PSI_INV^i if neg_mode, else N_INV.
//   DONE: out_valid=1, poly_c stable, in_ready=0. On out_ready, go to IDLE next cycle.
//  NTT outputs arriving in a state not waiting for them are ignored.
//  Latency: accept to out_valid <= 2*L_ntt+8 cycles. L_ntt is the core latency; the FSM waits on valid, so it is not hard-coded.
//  One job in flight; no overlap between jobs.
//  Arithmetic: modmul = (2W-bit product) % Modulus_Q, combinational, N parallel lanes. One multiplier bank is shared by TWIST/PMUL/SCALE.
//  TW/UT tables are elaboration-time constants (localparam arrays from package functions); no runtime table RAM.
//  Output is always reduced to [0,Q-1].
// STRUCTURE
//  poly_mult_pkg: modmul() and modpow() functions, pow_table(base,N) function, state enum poly_mult_state_t.
//  Sub-module: mod_mult_lane (one W-bit modular multiplier), generated N times, shared across stages.
//  Instance: ntt_block_radix2_pipelined u_ntt (W,N,Modulus_Q,OMEGA,OMEGA_INV).
// TESTING (default params)
//  T1 a=b={1,2,3,4,5,6,7,8}, neg_mode=1 -> c[0]=2147483631 (=Q-146), c[7]=120; all lanes match naive negacyclic model.
//  T2 same a,b, neg_mode=0 -> c[0]=148, c[7]=120; all lanes match naive cyclic model.
//  T3 a=x (a[1]=1), b=x^7, neg_mode=1 -> c[0]=Q-1=2147483776, others 0. neg_mode=0 -> c[0]=1.
//  T4 out_ready=0 for 10 cycles after out_valid -> poly_c/out_valid stable, in_ready=0; out_ready=1 -> in_ready=1 next cycle.
//  T5 reset pulsed during WAIT_NTT -> out_valid never rises for that job; next job (a=1, b={9..16}) returns c=b.
//  T6 200 random jobs, random neg_mode, in_valid/out_ready jitter -> all match model; latency <= 2*L_ntt+8.

Source files
------------

// File: rtl/poly_mult_pkg.sv
// Shared types and elaboration-time modular arithmetic helpers for the polynomial multiplier.
// Functions operate on a fixed wide word so the tables can be built for any lane width up to WMAX.
package poly_mult_pkg;

  localparam int WMAX  = 128;
  localparam int MAX_N = 64;

  typedef logic [MAX_N-1:0][WMAX-1:0] wtab_t;

  typedef enum logic [3:0] {
    S_IDLE,
    S_TWIST,
    S_SEND_A,
    S_SEND_B,
    S_WAIT_NTT,
    S_PMUL,
    S_SEND_C,
    S_WAIT_INTT,
    S_SCALE,
    S_DONE
  } poly_mult_state_t;

  function automatic logic [WMAX-1:0] modmul(input logic [WMAX-1:0] a,
                                             input logic [WMAX-1:0] b,
                                             input logic [WMAX-1:0] q);
    logic [2*WMAX-1:0] p;
    p = ({{WMAX{1'b0}}, a} * {{WMAX{1'b0}}, b}) % {{WMAX{1'b0}}, q};
    return p[WMAX-1:0];
  endfunction

  function automatic logic [WMAX-1:0] modpow(input logic [WMAX-1:0] base,
                                             input int e,
                                             input logic [WMAX-1:0] q);
    logic [WMAX-1:0] r;
    r = WMAX'(1);
    for (int k = 0; k < e; k++) r = modmul(r, base, q);
    return r;
  endfunction

  // Entry k holds base^k mod q for k < n; unused entries stay zero.
  function automatic wtab_t pow_table(input logic [WMAX-1:0] base,
                                      input int n,
                                      input logic [WMAX-1:0] q);
    wtab_t t;
    logic [WMAX-1:0] r;
    t = '0;
    r = WMAX'(1);
    for (int k = 0; k < MAX_N; k++) begin
      if (k < n) begin
        t[k] = r;
        r = modmul(r, base, q);
      end
    end
    return t;
  endfunction

  function automatic int bit_rev(input int v, input int bits);
    int r;
    r = 0;
    for (int k = 0; k < bits; k++) begin
      if (v[k]) r = r | (1 << (bits - 1 - k));
    end
    return r;
  endfunction

endpackage

// File: rtl/mod_mult_lane.sv
// One combinational W-bit modular multiplier: p = (x*y) mod Q over the full 2W-bit product.
module mod_mult_lane #(
  parameter int W = 100,
  parameter logic [W-1:0] Q = W'(64'd2147483777)
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic [W-1:0] p
);

  logic [2*W-1:0] prod_full;

  assign prod_full = {{W{1'b0}}, x} * {{W{1'b0}}, y};
  assign p = W'(prod_full % {{W{1'b0}}, Q});

endmodule

// File: rtl/ntt_block_radix2_pipelined.sv
// Radix-2 DIT NTT, one registered butterfly stage per log2(N) level; latency is log2(N) cycles.
// The inverse transform is unscaled (yields N*x); the caller applies N^-1.
module ntt_block_radix2_pipelined
  import poly_mult_pkg::*;
#(
  parameter int W = 100,
  parameter int N = 8,
  parameter logic [W-1:0] Modulus_Q = W'(64'd2147483777),
  parameter logic [W-1:0] OMEGA     = W'(64'd1061363846),
  parameter logic [W-1:0] OMEGA_INV = W'(64'd1237364089)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         data_valid_in,
  input  logic         iNTT_mode,
  input  logic [W-1:0] data_in [0:N-1],
  output logic         data_valid_out,
  output logic         mode_out,
  output logic [W-1:0] data_out [0:N-1]
);

  localparam int LOGN = $clog2(N);

  logic [W-1:0]    stage_data [0:LOGN][0:N-1];
  logic [LOGN-1:0] valid_reg;
  logic [LOGN-1:0] mode_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_reg <= '0;
      mode_reg  <= '0;
    end else begin
      valid_reg[0] <= data_valid_in;
      mode_reg[0]  <= iNTT_mode;
      for (int s = 1; s < LOGN; s++) begin
        valid_reg[s] <= valid_reg[s-1];
        mode_reg[s]  <= mode_reg[s-1];
      end
    end
  end

  genvar gi, gs, gb;
  generate
    for (gi = 0; gi < N; gi++) begin : g_io
      assign stage_data[0][gi] = data_in[bit_rev(gi, LOGN)];
      assign data_out[gi]      = stage_data[LOGN][gi];
    end

    for (gs = 0; gs < LOGN; gs++) begin : g_stage
      localparam int HALF = 1 << gs;
      logic md;
      // The mode bit travels with the data so fwd/inv jobs can share the pipe.
      if (gs == 0) begin : g_md_in
        assign md = iNTT_mode;
      end else begin : g_md_pipe
        assign md = mode_reg[gs-1];
      end

      for (gb = 0; gb < N/2; gb++) begin : g_bfly
        localparam int J  = gb % HALF;
        localparam int LO = (gb / HALF) * 2 * HALF + J;
        localparam int HI = LO + HALF;
        localparam int E  = J * (N / (2 * HALF));
        localparam logic [W-1:0] TWF = W'(modpow(WMAX'(OMEGA), E, WMAX'(Modulus_Q)));
        localparam logic [W-1:0] TWI = W'(modpow(WMAX'(OMEGA_INV), E, WMAX'(Modulus_Q)));

        logic [W-1:0] t;
        logic [W-1:0] diff;
        logic [W:0]   sum;
        logic [W-1:0] lo_reg;
        logic [W-1:0] hi_reg;

        mod_mult_lane #(.W(W), .Q(Modulus_Q)) u_mul (
          .x(stage_data[gs][HI]),
          .y(md ? TWI : TWF),
          .p(t)
        );

        assign sum  = {1'b0, stage_data[gs][LO]} + {1'b0, t};
        assign diff = stage_data[gs][LO] - t + ((stage_data[gs][LO] >= t) ? '0 : Modulus_Q);

        always_ff @(posedge clk) begin
          if (reset) begin
            lo_reg <= '0;
            hi_reg <= '0;
          end else begin
            lo_reg <= (sum >= {1'b0, Modulus_Q}) ? W'(sum - {1'b0, Modulus_Q}) : W'(sum);
            hi_reg <= diff;
          end
        end

        assign stage_data[gs+1][LO] = lo_reg;
        assign stage_data[gs+1][HI] = hi_reg;
      end
    end
  endgenerate

  assign data_valid_out = valid_reg[LOGN-1];
  assign mode_out       = mode_reg[LOGN-1];

endmodule

// File: rtl/negacyclic_poly_mult.sv
// Self-sequencing c = a*b mod (x^N +/- 1) mod Q: twist, NTT both operands, pointwise multiply,
// inverse NTT, then scale/untwist, all through one shared bank of N modular multipliers.
module negacyclic_poly_mult
  import poly_mult_pkg::*;
#(
  parameter int W = 100,
  parameter int N = 8,
  parameter logic [W-1:0] Modulus_Q = W'(64'd2147483777),
  parameter logic [W-1:0] OMEGA     = W'(64'd1061363846),
  parameter logic [W-1:0] OMEGA_INV = W'(64'd1237364089),
  parameter logic [W-1:0] PSI       = W'(64'd1323801281),
  parameter logic [W-1:0] PSI_INV   = W'(64'd2145878094),
  parameter logic [W-1:0] N_INV     = W'(64'd1879048305)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         neg_mode,
  input  logic [W-1:0] poly_a [0:N-1],
  input  logic [W-1:0] poly_b [0:N-1],
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] poly_c [0:N-1],
  output logic         busy
);

  localparam wtab_t PSI_TAB     = pow_table(WMAX'(PSI), N, WMAX'(Modulus_Q));
  localparam wtab_t PSI_INV_TAB = pow_table(WMAX'(PSI_INV), N, WMAX'(Modulus_Q));

  poly_mult_state_t state_reg, state_next;

  logic [W-1:0] a_reg      [0:N-1];
  logic [W-1:0] b_reg      [0:N-1];
  logic [W-1:0] work_reg   [0:N-1];
  logic [W-1:0] a_hat_reg  [0:N-1];
  logic [W-1:0] b_hat_reg  [0:N-1];
  logic [W-1:0] c_raw_reg  [0:N-1];
  logic [W-1:0] poly_c_reg [0:N-1];
  logic [W-1:0] prod       [0:N-1];
  logic [W-1:0] ntt_out    [0:N-1];
  logic         neg_reg;
  logic         got_a_reg;
  logic         ntt_valid_in, ntt_mode_in;
  logic         ntt_valid_out, ntt_mode_out;

  // Operand select per stage: TWIST twists a, SEND_A twists b while a_t is on the NTT input.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_lane
      localparam logic [W-1:0] TW_NEG = W'(PSI_TAB[gi]);
      localparam logic [W-1:0] UT_NEG =
        W'(modmul(WMAX'(N_INV), PSI_INV_TAB[gi], WMAX'(Modulus_Q)));
      logic [W-1:0] op_x, op_y;

      always_comb begin
        op_x = '0;
        op_y = '0;
        case (state_reg)
          S_TWIST:  begin op_x = a_reg[gi];     op_y = neg_reg ? TW_NEG : W'(1); end
          S_SEND_A: begin op_x = b_reg[gi];     op_y = neg_reg ? TW_NEG : W'(1); end
          S_PMUL:   begin op_x = a_hat_reg[gi]; op_y = b_hat_reg[gi];            end
          S_SCALE:  begin op_x = c_raw_reg[gi]; op_y = neg_reg ? UT_NEG : N_INV; end
          default: ;
        endcase
      end

      mod_mult_lane #(.W(W), .Q(Modulus_Q)) u_lane (
        .x(op_x),
        .y(op_y),
        .p(prod[gi])
      );
    end
  endgenerate

  ntt_block_radix2_pipelined #(
    .W(W), .N(N), .Modulus_Q(Modulus_Q), .OMEGA(OMEGA), .OMEGA_INV(OMEGA_INV)
  ) u_ntt (
    .clk(clk),
    .reset(reset),
    .data_valid_in(ntt_valid_in),
    .iNTT_mode(ntt_mode_in),
    .data_in(work_reg),
    .data_valid_out(ntt_valid_out),
    .mode_out(ntt_mode_out),
    .data_out(ntt_out)
  );

  always_comb begin
    state_next   = state_reg;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    ntt_valid_in = 1'b0;
    ntt_mode_in  = 1'b0;
    case (state_reg)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = S_TWIST;
      end
      S_TWIST:  state_next = S_SEND_A;
      S_SEND_A: begin ntt_valid_in = 1'b1; state_next = S_SEND_B; end
      S_SEND_B: begin ntt_valid_in = 1'b1; state_next = S_WAIT_NTT; end
      S_WAIT_NTT: begin
        if (ntt_valid_out && !ntt_mode_out && got_a_reg) state_next = S_PMUL;
      end
      S_PMUL: state_next = S_SEND_C;
      S_SEND_C: begin
        ntt_valid_in = 1'b1;
        ntt_mode_in  = 1'b1;
        state_next   = S_WAIT_INTT;
      end
      S_WAIT_INTT: begin
        if (ntt_valid_out && ntt_mode_out) state_next = S_SCALE;
      end
      S_SCALE: state_next = S_DONE;
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_IDLE;
      neg_reg   <= 1'b0;
      got_a_reg <= 1'b0;
      for (int i = 0; i < N; i++) begin
        a_reg[i]      <= '0;
        b_reg[i]      <= '0;
        work_reg[i]   <= '0;
        a_hat_reg[i]  <= '0;
        b_hat_reg[i]  <= '0;
        c_raw_reg[i]  <= '0;
        poly_c_reg[i] <= '0;
      end
    end else begin
      state_reg <= state_next;
      case (state_reg)
        S_IDLE: begin
          if (in_valid) begin
            a_reg     <= poly_a;
            b_reg     <= poly_b;
            neg_reg   <= neg_mode;
            got_a_reg <= 1'b0;
          end
        end
        S_TWIST, S_SEND_A, S_PMUL: work_reg <= prod;
        S_WAIT_NTT: begin
          if (ntt_valid_out && !ntt_mode_out) begin
            if (!got_a_reg) begin
              a_hat_reg <= ntt_out;
              got_a_reg <= 1'b1;
            end else begin
              b_hat_reg <= ntt_out;
            end
          end
        end
        S_WAIT_INTT: begin
          if (ntt_valid_out && ntt_mode_out) c_raw_reg <= ntt_out;
        end
        S_SCALE: poly_c_reg <= prod;
        default: ;
      endcase
    end
  end

  assign poly_c = poly_c_reg;
  assign busy   = (state_reg != S_IDLE);

endmodule

// File: tb/tb_negacyclic_poly_mult.sv
// Scoreboard bench for negacyclic_poly_mult: driver pushes expected results, monitor pops on handshake.
module tb_negacyclic_poly_mult;

  localparam int W = 100;
  localparam int N = 8;
  localparam logic [W-1:0] Q = W'(64'd2147483777);
  localparam int L_NTT   = 3;
  localparam int LAT_MAX = 2 * L_NTT + 8;

  typedef logic [N-1:0][W-1:0] vec_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         neg_mode = 1'b0;
  logic [W-1:0] poly_a [0:N-1];
  logic [W-1:0] poly_b [0:N-1];
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] poly_c [0:N-1];
  logic         busy;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   job_idx = 0;
  bit   stall = 1'b0;
  bit   jitter = 1'b0;
  vec_t sb_c[$];
  int   sb_t[$];

  longint t1n [N] = '{-146, -160, -160, -144, -110, -56, 20, 120};
  longint t2c [N] = '{148, 168, 180, 184, 180, 168, 148, 120};

  negacyclic_poly_mult dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .neg_mode(neg_mode), .poly_a(poly_a), .poly_b(poly_b),
    .out_valid(out_valid), .out_ready(out_ready), .poly_c(poly_c), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t from_signed(input longint v [N]);
    vec_t r;
    for (int i = 0; i < N; i++) r[i] = (v[i] < 0) ? (Q - W'(-v[i])) : W'(v[i]);
    return r;
  endfunction

  // Schoolbook product with wrap sign chosen by the ring.
  function automatic vec_t model(input vec_t a, input vec_t b, input bit neg);
    vec_t c;
    logic [W-1:0] p;
    int k;
    c = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        p = (a[i] * b[j]) % Q;
        k = i + j;
        if (k >= N) begin
          k = k - N;
          if (neg) p = (Q - p) % Q;
        end
        c[k] = (c[k] + p) % Q;
      end
    end
    return c;
  endfunction

  task automatic send(input vec_t a, input vec_t b, input bit neg, input bit push, input vec_t exp);
    int guard;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      poly_a[i] = a[i];
      poly_b[i] = b[i];
    end
    neg_mode = neg;
    in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: in_ready=0 after %0d cycles, expected 1", guard);
      in_valid = 1'b0;
      return;
    end
    if (push) begin
      sb_c.push_back(exp);
      sb_t.push_back(cyc + 1);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((sb_c.size() != 0 || !in_ready) && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    check("drain_pending", W'(sb_c.size()), '0);
  endtask

  // out_ready changes well after the edge so the monitor's negedge view is settled.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      out_ready = stall ? 1'b0 : (jitter ? ($urandom_range(0, 3) != 0) : 1'b1);
    end
  end

  initial begin
    bit valid_seen;
    vec_t e;
    int lat;
    valid_seen = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        valid_seen = 1'b0;
      end else if (out_valid) begin
        if (sb_c.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL spurious_out_valid: out_valid=1 with no job pending, expected 0");
        end else begin
          if (!valid_seen) begin
            valid_seen = 1'b1;
            lat = cyc - sb_t[0];
            n_cmp++;
            if (lat > LAT_MAX) begin
              n_bad++;
              $display("FAIL latency job%0d: %0d cycles, required <= %0d", job_idx, lat, LAT_MAX);
            end
          end
          if (out_ready) begin
            e = sb_c.pop_front();
            void'(sb_t.pop_front());
            for (int i = 0; i < N; i++)
              check($sformatf("job%0d_c%0d", job_idx, i), poly_c[i], e[i]);
            $display("job %0d: c[0]=%0d c[7]=%0d", job_idx, poly_c[0], poly_c[N-1]);
            job_idx++;
            valid_seen = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t seq, xa, xb, one, b9, ra, rb, exp;
    bit neg;
    int guard;

    for (int i = 0; i < N; i++) begin
      poly_a[i] = '0;
      poly_b[i] = '0;
    end
    seq = '0; xa = '0; xb = '0; one = '0; b9 = '0;
    for (int i = 0; i < N; i++) begin
      seq[i] = W'(i + 1);
      b9[i]  = W'(i + 9);
    end
    xa[1] = W'(1);
    xb[N-1] = W'(1);
    one[0] = W'(1);

    repeat (3) @(negedge clk);
    check("rst_in_ready", W'(in_ready), W'(1));
    check("rst_out_valid", W'(out_valid), '0);
    check("rst_busy", W'(busy), '0);
    for (int i = 0; i < N; i++) check($sformatf("rst_c%0d", i), poly_c[i], '0);
    reset = 1'b0;

    // T1..T3 directed
    send(seq, seq, 1'b1, 1'b1, from_signed(t1n));
    send(seq, seq, 1'b0, 1'b1, from_signed(t2c));
    exp = '0; exp[0] = Q - W'(1);
    send(xa, xb, 1'b1, 1'b1, exp);
    exp = '0; exp[0] = W'(1);
    send(xa, xb, 1'b0, 1'b1, exp);
    drain();

    // T4 output backpressure
    stall = 1'b1;
    send(seq, seq, 1'b1, 1'b1, from_signed(t1n));
    guard = 0;
    while (!out_valid && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    for (int k = 0; k < 10; k++) begin
      check("t4_out_valid_held", W'(out_valid), W'(1));
      check("t4_in_ready_low", W'(in_ready), '0);
      check("t4_busy", W'(busy), W'(1));
      check("t4_c0_stable", poly_c[0], Q - W'(146));
      check("t4_c7_stable", poly_c[N-1], W'(120));
      @(negedge clk);
    end
    stall = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("t4_in_ready_after", W'(in_ready), W'(1));
    check("t4_out_valid_after", W'(out_valid), '0);

    // T5 reset while waiting on the forward NTT
    send(seq, seq, 1'b1, 1'b0, '0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("t5_in_ready_after_rst", W'(in_ready), W'(1));
    for (int k = 0; k < 30; k++) begin
      check("t5_no_out_valid", W'(out_valid), '0);
      @(negedge clk);
    end
    send(one, b9, 1'b1, 1'b1, b9);
    drain();

    // T6 random jobs with handshake jitter
    jitter = 1'b1;
    for (int j = 0; j < 200; j++) begin
      for (int i = 0; i < N; i++) begin
        ra[i] = ($urandom_range(0, 9) == 0) ? Q - W'(1) : W'($urandom) % Q;
        rb[i] = ($urandom_range(0, 9) == 0) ? Q - W'(1) : W'($urandom) % Q;
      end
      neg = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(ra, rb, neg, 1'b1, model(ra, rb, neg));
    end
    drain();
    jitter = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
